// File: rtl/line_frame_counter_pkg.sv
// Shared types and default widths for the line/frame counter.
// Optional build macro LFC_FRAME_CNT_EN adds an 8-bit frame counter output.
package lfc_pkg;

    localparam int LFC_CNT_W    = 12;
    localparam int LFC_ROW_W    = 11;
    localparam int LFC_TEST_LEN = 16;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } lfc_state_e;

endpackage

// File: rtl/line_frame_counter_if.sv
// Control/status bundle between the pattern control FSM (master) and the counter (slave).
// frame_cnt exists only when LFC_FRAME_CNT_EN is defined.
interface line_frame_counter_if
    import lfc_pkg::*;
#(
    parameter int CNT_W = LFC_CNT_W,
    parameter int ROW_W = LFC_ROW_W
) ();

    logic             enb;
    logic             test;
    logic [CNT_W-1:0] line_len;
    logic [ROW_W-1:0] frame_lines;

    logic [CNT_W-1:0] col_cnt;
    logic [ROW_W-1:0] row_cnt;
    logic             endLine;
    logic             endFrame;
    logic             busy;
`ifdef LFC_FRAME_CNT_EN
    logic [7:0]       frame_cnt;
`endif

    modport master (
        output enb, test, line_len, frame_lines,
        input  col_cnt, row_cnt, endLine, endFrame, busy
`ifdef LFC_FRAME_CNT_EN
        , input frame_cnt
`endif
    );

    modport slave (
        input  enb, test, line_len, frame_lines,
        output col_cnt, row_cnt, endLine, endFrame, busy
`ifdef LFC_FRAME_CNT_EN
        , output frame_cnt
`endif
    );

endinterface

// File: rtl/line_frame_counter_term_counter.sv
// Up-counter that wraps to zero after reaching a programmable terminal value.
// at_term_nxt compares the value the counter will hold after this edge.
module term_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         inc,
    input  logic [W-1:0] term,
    output logic [W-1:0] cnt,
    output logic         at_term,
    output logic         at_term_nxt
);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc) begin
            cnt_d = at_term ? '0 : cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt         = cnt_q;
    assign at_term     = (cnt_q == term);
    assign at_term_nxt = (cnt_d == term);

endmodule

// File: rtl/line_frame_counter.sv
// Column/row counter with registered end-of-line and end-of-frame strobes.
// Define LFC_FRAME_CNT_EN to add an 8-bit wrapping frame counter.
//
// state | meaning
// IDLE  | counters and strobes held at 0; config latched on first edge with enb=1
// RUN   | counting with the latched line length / lines per frame
module line_frame_counter
    import lfc_pkg::*;
#(
    parameter int CNT_W    = LFC_CNT_W,
    parameter int ROW_W    = LFC_ROW_W,
    parameter int TEST_LEN = LFC_TEST_LEN
) (
    input  logic                 clk,
    input  logic                 rst_n,
    line_frame_counter_if.slave  bus
);

    localparam logic [CNT_W-1:0] TEST_TERM = CNT_W'(TEST_LEN - 1);

    lfc_state_e       state_q, state_d;
    logic             cfg_test_q, cfg_test_d;
    logic [CNT_W-1:0] cfg_len_q, cfg_len_d;
    logic [ROW_W-1:0] cfg_rows_q, cfg_rows_d;
    logic             end_line_q, end_line_d;
    logic             end_frame_q, end_frame_d;
`ifdef LFC_FRAME_CNT_EN
    logic [7:0]       frame_cnt_q, frame_cnt_d;
`endif

    logic [CNT_W-1:0] t_col;
    logic [ROW_W-1:0] t_row;
    logic             run_cnt;
    logic [CNT_W-1:0] col_cnt;
    logic [ROW_W-1:0] row_cnt;
    logic             col_at_term, col_at_term_nxt;
    logic             row_at_term_unused, row_at_term_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cfg_test_q  <= 1'b0;
            cfg_len_q   <= '0;
            cfg_rows_q  <= '0;
            end_line_q  <= 1'b0;
            end_frame_q <= 1'b0;
`ifdef LFC_FRAME_CNT_EN
            frame_cnt_q <= '0;
`endif
        end else begin
            state_q     <= state_d;
            cfg_test_q  <= cfg_test_d;
            cfg_len_q   <= cfg_len_d;
            cfg_rows_q  <= cfg_rows_d;
            end_line_q  <= end_line_d;
            end_frame_q <= end_frame_d;
`ifdef LFC_FRAME_CNT_EN
            frame_cnt_q <= frame_cnt_d;
`endif
        end
    end

    always_comb begin
        state_d    = state_q;
        cfg_test_d = cfg_test_q;
        cfg_len_d  = cfg_len_q;
        cfg_rows_d = cfg_rows_q;
        unique case (state_q)
            IDLE: begin
                if (bus.enb) begin
                    state_d    = RUN;
                    cfg_test_d = bus.test;
                    cfg_len_d  = bus.line_len;
                    cfg_rows_d = bus.frame_lines;
                end
            end
            RUN: begin
                if (!bus.enb) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Terminals follow the config being latched this edge, so the first RUN
    // cycle's strobes already reflect the new line length.
    assign t_col = cfg_test_d ? TEST_TERM : cfg_len_d - CNT_W'(1);
    assign t_row = cfg_rows_d - ROW_W'(1);

    always_comb begin
        run_cnt     = (state_q == RUN) && bus.enb;
        end_line_d  = (state_d == RUN) && col_at_term_nxt;
        end_frame_d = end_line_d && row_at_term_nxt;
`ifdef LFC_FRAME_CNT_EN
        frame_cnt_d = frame_cnt_q;
        if (state_d == IDLE) begin
            frame_cnt_d = '0;
        end else if (end_frame_q) begin
            frame_cnt_d = frame_cnt_q + 8'd1;
        end
`endif
    end

    term_counter #(.W(CNT_W)) u_col (
        .clk         (clk),
        .rst_n       (rst_n),
        .clr         (!run_cnt),
        .inc         (run_cnt),
        .term        (t_col),
        .cnt         (col_cnt),
        .at_term     (col_at_term),
        .at_term_nxt (col_at_term_nxt)
    );

    // Row wrap is handled inside the counter; only the look-ahead compare is used here.
    term_counter #(.W(ROW_W)) u_row (
        .clk         (clk),
        .rst_n       (rst_n),
        .clr         (!run_cnt),
        .inc         (run_cnt && col_at_term),
        .term        (t_row),
        .cnt         (row_cnt),
        .at_term     (row_at_term_unused),
        .at_term_nxt (row_at_term_nxt)
    );

    assign bus.col_cnt  = col_cnt;
    assign bus.row_cnt  = row_cnt;
    assign bus.endLine  = end_line_q;
    assign bus.endFrame = end_frame_q;
    assign bus.busy     = (state_q == RUN);
`ifdef LFC_FRAME_CNT_EN
    assign bus.frame_cnt = frame_cnt_q;
`endif

endmodule

// File: tb/tb_line_frame_counter.sv
// Self-checking bench for line_frame_counter: directed table, corner sequences and
// randomized stimulus against an arithmetic model (elapsed RUN cycles -> col/row).
module tb_line_frame_counter;
    import lfc_pkg::*;

    localparam int CNT_W    = 12;
    localparam int ROW_W    = 11;
    localparam int TEST_LEN = 16;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    line_frame_counter_if #(.CNT_W(CNT_W), .ROW_W(ROW_W)) bus ();

    line_frame_counter #(.CNT_W(CNT_W), .ROW_W(ROW_W), .TEST_LEN(TEST_LEN)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // model: whether running, cycles elapsed since entering RUN, latched geometry
    bit     m_run;
    longint m_n;
    int     m_L, m_R;
    int     m_fc;
    int     e_col, e_row;
    bit     e_el, e_ef;

    typedef struct {
        bit enb;
        bit test;
        int len;
        int rows;
        int ncyc;
        int e_col;
        int e_row;
        bit e_el;
        bit e_ef;
        bit e_busy;
    } vec_t;

    vec_t vecs[17];

    function automatic void model_outs();
        if (m_run) begin
            e_col = int'(m_n % longint'(m_L));
            e_row = int'((m_n / longint'(m_L)) % longint'(m_R));
            e_el  = (e_col == m_L - 1);
            e_ef  = e_el && (e_row == m_R - 1);
        end else begin
            e_col = 0;
            e_row = 0;
            e_el  = 1'b0;
            e_ef  = 1'b0;
        end
    endfunction

    function automatic void model_reset();
        m_run = 1'b0;
        m_n   = 0;
        m_L   = 1;
        m_R   = 1;
        m_fc  = 0;
    endfunction

    task automatic chk(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_all();
        model_outs();
        chk("col_cnt",  longint'(bus.col_cnt),  longint'(e_col));
        chk("row_cnt",  longint'(bus.row_cnt),  longint'(e_row));
        chk("endLine",  longint'(bus.endLine),  longint'(e_el));
        chk("endFrame", longint'(bus.endFrame), longint'(e_ef));
        chk("busy",     longint'(bus.busy),     longint'(m_run));
`ifdef LFC_FRAME_CNT_EN
        chk("frame_cnt", longint'(bus.frame_cnt), longint'(m_fc));
`endif
    endtask

    task automatic step();
        bit ef_prev;
        @(posedge clk);
        model_outs();
        ef_prev = e_ef;
        if (!bus.enb) begin
            m_run = 1'b0;
            m_n   = 0;
            m_fc  = 0;
        end else if (!m_run) begin
            m_run = 1'b1;
            m_n   = 0;
            m_L   = bus.test ? TEST_LEN
                  : (bus.line_len == '0 ? (1 << CNT_W) : int'(bus.line_len));
            m_R   = (bus.frame_lines == '0) ? (1 << ROW_W) : int'(bus.frame_lines);
        end else begin
            m_n++;
            if (ef_prev) m_fc = (m_fc + 1) % 256;
        end
        #1;
        check_all();
    endtask

    task automatic drive(input bit enb, input bit test, input int len, input int rows);
        bus.enb         = enb;
        bus.test        = test;
        bus.line_len    = CNT_W'(len);
        bus.frame_lines = ROW_W'(rows);
    endtask

    initial begin
        //           enb test len   rows ncyc  col   row el ef busy
        vecs[0]  = '{0, 0,   0,    0,   5,    0,    0,  0, 0, 0};
        vecs[1]  = '{1, 0,   100,  4,   400,  99,   3,  1, 1, 1};
        vecs[2]  = '{1, 0,   100,  4,   1,    0,    0,  0, 0, 1};
        vecs[3]  = '{1, 0,   100,  4,   99,   99,   0,  1, 0, 1};
        vecs[4]  = '{0, 0,   100,  4,   1,    0,    0,  0, 0, 0};
        vecs[5]  = '{1, 1,   4000, 4,   16,   15,   0,  1, 0, 1};
        vecs[6]  = '{1, 0,   200,  4,   48,   15,   3,  1, 1, 1};
        vecs[7]  = '{0, 0,   1,    3,   1,    0,    0,  0, 0, 0};
        vecs[8]  = '{1, 0,   1,    3,   1,    0,    0,  1, 0, 1};
        vecs[9]  = '{1, 0,   1,    3,   2,    0,    2,  1, 1, 1};
        vecs[10] = '{0, 0,   0,    1,   1,    0,    0,  0, 0, 0};
        vecs[11] = '{1, 0,   0,    1,   4096, 4095, 0,  1, 1, 1};
        vecs[12] = '{1, 0,   0,    1,   1,    0,    0,  0, 0, 1};
        vecs[13] = '{0, 0,   10,   0,   1,    0,    0,  0, 0, 0};
        vecs[14] = '{1, 0,   10,   0,   8,    7,    0,  0, 0, 1};
        vecs[15] = '{0, 0,   20,   0,   1,    0,    0,  0, 0, 0};
        vecs[16] = '{1, 0,   20,   0,   20,   19,   0,  1, 0, 1};

        model_reset();
        drive(0, 0, 0, 0);
        #2 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check_all();
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            drive(vecs[i].enb, vecs[i].test, vecs[i].len, vecs[i].rows);
            repeat (vecs[i].ncyc) step();
            chk($sformatf("vec%0d_col", i),   longint'(bus.col_cnt),  longint'(vecs[i].e_col));
            chk($sformatf("vec%0d_row", i),   longint'(bus.row_cnt),  longint'(vecs[i].e_row));
            chk($sformatf("vec%0d_eline", i), longint'(bus.endLine),  longint'(vecs[i].e_el));
            chk($sformatf("vec%0d_efrm", i),  longint'(bus.endFrame), longint'(vecs[i].e_ef));
            chk($sformatf("vec%0d_busy", i),  longint'(bus.busy),     longint'(vecs[i].e_busy));
        end

        // enb drop exactly on a wrap edge: no strobe may survive the clear
        drive(0, 0, 0, 0);
        step();
        drive(1, 0, 3, 1);
        repeat (3) step();
        chk("wrap_pre_el", longint'(bus.endFrame), 1);
        drive(0, 0, 3, 1);
        step();
        chk("wrap_drop_el", longint'(bus.endLine), 0);
        step();
        chk("wrap_idle_el", longint'(bus.endLine), 0);

        // asynchronous reset in the middle of a frame
        drive(1, 0, 5, 2);
        repeat (7) step();
        chk("prerst_col", longint'(bus.col_cnt), 1);
        #3 rst_n = 1'b0;
        #1;
        model_reset();
        chk("rst_col",  longint'(bus.col_cnt),  0);
        chk("rst_row",  longint'(bus.row_cnt),  0);
        chk("rst_el",   longint'(bus.endLine),  0);
        chk("rst_ef",   longint'(bus.endFrame), 0);
        chk("rst_busy", longint'(bus.busy),     0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (6) step();

        for (int k = 0; k < 200; k++) begin
            drive(($urandom % 6) != 0,
                  ($urandom % 4) == 0,
                  (($urandom % 5) == 0) ? 0 : int'($urandom_range(1, 12)),
                  int'($urandom_range(0, 4)));
            repeat ($urandom_range(1, 30)) step();
        end

`ifdef LFC_FRAME_CNT_EN
        drive(0, 0, 2, 2);
        step();
        drive(1, 0, 2, 2);
        repeat (1030) step();
        chk("frame_cnt_wrap", longint'(bus.frame_cnt), 1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
